// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch buffer: sequential halfword fetches over a req/ack
// memory handshake, queued with their PCs and handed to decode via valid/ready.
module inst_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        inst_valid,
  output logic [15:0] inst_data,
  output logic [15:0] inst_pc,
  input  logic        inst_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t        state;
  logic [15:0]   fetch_pc;
  logic [15:0]   req_addr;
  logic [15:0]   mem_data [DEPTH];
  logic [15:0]   mem_pc   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [15:0]   target_pc;
  logic [15:0]   step_pc;
  logic          push;
  logic          pop;

  assign target_pc = {redirect_pc[15:1], 1'b0};
  assign step_pc   = fetch_pc + PC_STEP;

  // Data returning in the same cycle as a redirect belongs to the old stream.
  assign push = (state == FETCH) && imem_ack && !redirect_valid;
  assign pop  = inst_valid && inst_ready && !redirect_valid;

  always_comb begin
    count_next = count;
    if (redirect_valid)
      count_next = '0;
    else if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
  end

  // The request address is held in req_addr so a redirect during an
  // outstanding request can retarget fetch_pc without disturbing the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      imem_req <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) begin
            fetch_pc <= target_pc;
            req_addr <= target_pc;
            imem_req <= 1'b1;
            state    <= FETCH;
          end else if (count < FULL) begin
            req_addr <= fetch_pc;
            imem_req <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (redirect_valid) begin
            fetch_pc <= target_pc;
            if (imem_ack)
              req_addr <= target_pc;
            else
              state <= DRAIN;
          end else if (imem_ack) begin
            fetch_pc <= step_pc;
            req_addr <= step_pc;
            if (count_next >= FULL) begin
              imem_req <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (redirect_valid)
            fetch_pc <= target_pc;
          if (imem_ack) begin
            req_addr <= redirect_valid ? target_pc : fetch_pc;
            state    <= FETCH;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else begin
      count <= count_next;
      if (redirect_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          mem_data[wr_ptr] <= imem_rdata;
          mem_pc[wr_ptr]   <= fetch_pc;
          wr_ptr           <= wr_ptr + 1'b1;
        end
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign imem_addr  = req_addr;
  assign inst_valid = (count != '0);
  assign inst_data  = mem_data[rd_ptr];
  assign inst_pc    = mem_pc[rd_ptr];

endmodule
